// File: rtl/alive_cmd_responder.sv
// alive_cmd_responder: 4-phase req/ack command responder with scratch regs and heartbeat.
// Revision 1.0
`default_nettype none

module alive_cmd_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int HB_BITS     = 24,
  parameter int NREGS       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WR    = 4'd1;
  localparam logic [3:0] OP_RD    = 4'd2;
  localparam logic [3:0] OP_RD_HB = 4'd3;
  localparam logic [3:0] OP_CLR   = 4'd4;
  localparam logic [HB_BITS-1:0] HB_ONE = {{(HB_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic [3:0]             op_q;
  logic [1:0]             addr_q;
  logic [7:0]             data_q;
  logic [7:0]             regs [NREGS];
  logic [HB_BITS-1:0]     hb;
  logic                   err;
  logic                   oe;
  logic [3:0]             done_cnt;
  logic [7:0]             rd_data;
  logic                   capture;
  logic                   execute;
  logic                   legal;
  logic                   unused_ui6;

  assign unused_ui6 = ui_in[6];
  assign req_s      = req_sync[SYNC_STAGES-1];
  assign capture    = (state == IDLE) && (state_nxt == EXEC);
  assign execute    = ena && (state == EXEC);
  assign legal      = (op_q <= OP_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (req_s) state_nxt = EXEC;
        EXEC:    state_nxt = ACK;
        ACK:     if (!req_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // req is the only asynchronous control; opcode/addr/data are held stable by the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], ui_in[7]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb <= '0;
    end else if (ena) begin
      hb <= hb + HB_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_NOP;
      addr_q   <= 2'd0;
      data_q   <= 8'h00;
      err      <= 1'b0;
      oe       <= 1'b0;
      done_cnt <= 4'd0;
      rd_data  <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      if (capture) begin
        op_q   <= ui_in[3:0];
        addr_q <= ui_in[5:4];
        data_q <= uio_in;
      end
      if (execute) begin
        if (legal) begin
          err      <= 1'b0;
          done_cnt <= done_cnt + 4'd1;
        end else begin
          err <= 1'b1;
        end
        case (op_q)
          OP_WR:    regs[addr_q] <= data_q;
          OP_RD:    rd_data <= regs[addr_q];
          OP_RD_HB: rd_data <= hb[HB_BITS-1 -: 8];
          OP_CLR:   for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
          default:  ;
        endcase
        oe <= (op_q == OP_RD) || (op_q == OP_RD_HB);
      end else if (!ena || ((state == ACK) && !req_s)) begin
        oe <= 1'b0;
      end
    end
  end

  assign uo_out  = {(state == ACK), hb[HB_BITS-1], err, (state != IDLE), done_cnt};
  assign uio_out = rd_data;
  assign uio_oe  = {8{oe}};

endmodule

`default_nettype wire

// File: tb/tb_alive_cmd_responder.sv
// tb_alive_cmd_responder: directed handshake tests for alive_cmd_responder (HB_BITS=10).
`default_nettype none

module tb_alive_cmd_responder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors;
  int checks;

  alive_cmd_responder #(
    .SYNC_STAGES(2),
    .HB_BITS    (10),
    .NREGS      (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full handshake; returns data/oe seen while ack=1 and whether both waits completed.
  task automatic issue(input logic [3:0] op, input logic [1:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic [7:0] oe, output bit ok);
    int n;
    ui_in  = {1'b1, 1'b0, a, op};
    uio_in = d;
    n = 0;
    while (uo_out[7] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (uo_out[7] === 1'b1);
    rd = uio_out;
    oe = uio_oe;
    ui_in[7] = 1'b0;
    n = 0;
    while (uo_out[7] !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = ok && (uo_out[7] === 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({uo_out, uio_out, uio_oe} !== 24'h0) begin
      errors++;
      $display("FAIL in_reset: uo=%h uio_out=%h oe=%h expected all 00", uo_out, uio_out, uio_oe);
    end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_reset: uo=%h oe=%h expected 00/00", uo_out, uio_oe);
    end
  endtask

  task automatic test_wr_rd();
    logic [7:0] rd, oe;
    bit ok;
    @(posedge clk); #1;
    ui_in  = {1'b1, 1'b0, 2'd2, 4'd1};
    uio_in = 8'hA5;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (uo_out[7] !== 1'b0 || uo_out[4] !== 1'b1) begin
      errors++;
      $display("FAIL ack_at_N2: ack=%b busy=%b expected 0/1", uo_out[7], uo_out[4]);
    end
    @(posedge clk); #1;
    checks++;
    if (uo_out[7] !== 1'b1) begin
      errors++;
      $display("FAIL ack_at_N3: ack=%b expected 1", uo_out[7]);
    end
    ui_in[7] = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (uo_out[7] !== 1'b1) begin
      errors++;
      $display("FAIL ack_hold_M1: ack=%b expected 1", uo_out[7]);
    end
    @(posedge clk); #1;
    checks++;
    if (uo_out !== 8'h01) begin
      errors++;
      $display("FAIL ack_drop_M2: uo=%h expected 01", uo_out);
    end
    issue(4'd2, 2'd2, 8'h00, rd, oe, ok);
    checks++;
    if (!ok || rd !== 8'hA5 || oe !== 8'hFF) begin
      errors++;
      $display("FAIL rd_reg2: ok=%0d data=%h oe=%h expected 1/a5/ff", ok, rd, oe);
    end
    checks++;
    if (uo_out[3:0] !== 4'd2 || uio_oe !== 8'h00 || uio_out !== 8'hA5) begin
      errors++;
      $display("FAIL rd_after: done=%0d oe=%h data=%h expected 2/00/a5",
               uo_out[3:0], uio_oe, uio_out);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] rd, oe;
    bit ok;
    issue(4'd9, 2'd0, 8'h00, rd, oe, ok);
    checks++;
    if (!ok || uo_out[5] !== 1'b1 || uo_out[3:0] !== 4'd2 || oe !== 8'h00) begin
      errors++;
      $display("FAIL illegal_op: ok=%0d err=%b done=%0d oe=%h expected 1/1/2/00",
               ok, uo_out[5], uo_out[3:0], oe);
    end
    issue(4'd0, 2'd0, 8'h00, rd, oe, ok);
    checks++;
    if (!ok || uo_out[5] !== 1'b0 || uo_out[3:0] !== 4'd3) begin
      errors++;
      $display("FAIL nop_clears_err: ok=%0d err=%b done=%0d expected 1/0/3",
               ok, uo_out[5], uo_out[3:0]);
    end
  endtask

  task automatic test_clr_and_wrap();
    logic [7:0] rd, oe;
    logic [7:0] pat;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      pat = 8'h11 * (i + 1);
      issue(4'd1, i[1:0], pat, rd, oe, ok);
    end
    issue(4'd2, 2'd3, 8'h00, rd, oe, ok);
    checks++;
    if (!ok || rd !== 8'h44) begin
      errors++;
      $display("FAIL rd_reg3_before_clr: ok=%0d data=%h expected 44", ok, rd);
    end
    issue(4'd4, 2'd0, 8'h00, rd, oe, ok);
    for (int i = 0; i < 4; i++) begin
      issue(4'd2, i[1:0], 8'h00, rd, oe, ok);
      checks++;
      if (!ok || rd !== 8'h00) begin
        errors++;
        $display("FAIL rd_after_clr_%0d: ok=%0d data=%h expected 00", i, ok, rd);
      end
    end
    checks++;
    if (uo_out[3:0] !== 4'd13) begin
      errors++;
      $display("FAIL done_after_clr: done=%0d expected 13", uo_out[3:0]);
    end
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      issue(4'd0, 2'd0, 8'h00, rd, oe, ok);
      if (i >= 14) begin
        checks++;
        if (!ok || uo_out[3:0] !== 4'((i + 1) % 16)) begin
          errors++;
          $display("FAIL done_wrap_%0d: ok=%0d done=%0d expected %0d",
                   i + 1, ok, uo_out[3:0], (i + 1) % 16);
        end
      end
    end
  endtask

  task automatic test_heartbeat();
    logic [7:0] rd, oe;
    bit ok;
    apply_reset();
    repeat (511) @(posedge clk);
    #1;
    checks++;
    if (uo_out[6] !== 1'b0) begin
      errors++;
      $display("FAIL hb_511: msb=%b expected 0", uo_out[6]);
    end
    @(posedge clk); #1;
    checks++;
    if (uo_out[6] !== 1'b1) begin
      errors++;
      $display("FAIL hb_512: msb=%b expected 1", uo_out[6]);
    end
    ena = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (uo_out !== 8'h40) begin
      errors++;
      $display("FAIL hb_frozen: uo=%h expected 40", uo_out);
    end
    // hb=512 frozen; 3 more increments before the EXEC edge samples 515 -> 0x80.
    ena = 1'b1;
    issue(4'd3, 2'd0, 8'h00, rd, oe, ok);
    checks++;
    if (!ok || rd !== 8'h80 || oe !== 8'hFF) begin
      errors++;
      $display("FAIL rd_hb: ok=%0d data=%h oe=%h expected 1/80/ff", ok, rd, oe);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd, oe;
    bit ok;
    int n;
    issue(4'd1, 2'd1, 8'h5A, rd, oe, ok);
    ui_in = {1'b1, 1'b0, 2'd1, 4'd2};
    n = 0;
    while (uo_out[7] !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (uo_out[7] !== 1'b1 || uio_oe !== 8'hFF || uio_out !== 8'h5A) begin
      errors++;
      $display("FAIL rd_before_abort: ack=%b oe=%h data=%h expected 1/ff/5a",
               uo_out[7], uio_oe, uio_out);
    end
    #2 rst_n = 1'b0;
    ui_in = 8'h00;
    #1;
    checks++;
    if ({uo_out, uio_out, uio_oe} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset: uo=%h data=%h oe=%h expected 00/00/00", uo_out, uio_out, uio_oe);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    issue(4'd2, 2'd1, 8'h00, rd, oe, ok);
    checks++;
    if (!ok || rd !== 8'h00) begin
      errors++;
      $display("FAIL reg_cleared_by_reset: ok=%0d data=%h expected 00", ok, rd);
    end
    @(posedge clk); #1;
    ui_in  = {1'b1, 1'b0, 2'd0, 4'd1};
    uio_in = 8'h77;
    n = 0;
    while (uo_out[4] !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    ena = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (n >= 10 || uo_out[7] !== 1'b0 || uo_out[4] !== 1'b0 || uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL ena_drop_in_exec: waited=%0d ack=%b busy=%b oe=%h expected ack0 busy0 oe00",
               n, uo_out[7], uo_out[4], uio_oe);
    end
    ui_in[7] = 1'b0;
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    issue(4'd2, 2'd0, 8'h00, rd, oe, ok);
    checks++;
    if (!ok || rd !== 8'h00 || uo_out[3:0] !== 4'd2) begin
      errors++;
      $display("FAIL aborted_wr_no_effect: ok=%0d data=%h done=%0d expected 1/00/2",
               ok, rd, uo_out[3:0]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_wr_rd();
    test_illegal();
    test_clr_and_wrap();
    test_heartbeat();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
